inst_fetch_seq: RTL

Program-counter sequencer that sits directly downstream of the ALU. It consumes the ALU branch flag (Out[0] of a Bgtz op, 101) to select the next fetch address. It drives the instruction-memory address and run/done status for the 8-bit processor. All outputs are registered. The PC advances one instruction per cycle while running.

---
 rtl/inst_fetch_seq_pkg.sv | 16 +
 rtl/inst_fetch_seq_next.sv | 34 +++
 rtl/inst_fetch_seq.sv | 99 +++++++++
 3 files changed

// File: rtl/inst_fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM states, default widths
// and the branch opcode used together with the ALU and the decoder.
package inst_fetch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } fetch_state_t;

  localparam int unsigned PC_W_DEF  = 10;
  localparam int unsigned CNT_W_DEF = 16;

  localparam logic [2:0] OP_BGTZ = 3'b101;

endpackage

// File: rtl/inst_fetch_seq_next.sv
// Candidate next fetch address: taken branch (absolute or PC-relative) or sequential +1.
// All sums wrap modulo 2^PC_W.
module pc_next_calc #(
  parameter int unsigned PC_W = 10
) (
  input  logic [PC_W-1:0] prog_ctr,
  input  logic [PC_W-1:0] target,
  input  logic            branch_en,
  input  logic            branch_abs,
  input  logic            alu_flag,
  output logic [PC_W-1:0] next_pc
);

  logic            taken;
  logic [PC_W:0]   offset_ext;
  logic [PC_W:0]   rel_sum;

  assign taken = branch_en & alu_flag;

  // Sign-extend the offset one bit, then drop the carry so that both directions wrap.
  always_comb begin
    offset_ext = {target[PC_W-1], target};
    rel_sum    = {1'b0, prog_ctr} + offset_ext;
    next_pc    = prog_ctr + PC_W'(1);
    if (taken) begin
      if (branch_abs) begin
        next_pc = target;
      end else begin
        next_pc = rel_sum[PC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/inst_fetch_seq.sv
// Program-counter sequencer for the 8-bit processor: IDLE/RUN/HALTED control,
// registered fetch address, status flags and a saturating retired-instruction counter.
module inst_fetch_seq
  import inst_fetch_seq_pkg::*;
#(
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             BranchAbs,
  input  logic             AluFlag,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic [PC_W-1:0]  pc_next;

  pc_next_calc #(.PC_W(PC_W)) u_pc_next_calc (
    .prog_ctr   (pc_q),
    .target     (Target),
    .branch_en  (BranchEn),
    .branch_abs (BranchAbs),
    .alu_flag   (AluFlag),
    .next_pc    (pc_next)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (Halt)  state_d = HALTED;
      HALTED:  if (Start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are derived from the next state so they register together with it.
  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    running_d = (state_d == RUN);
    done_d    = (state_d == HALTED);
    case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          pc_d  = PC_W'(START_ADDR);
          cnt_d = '0;
        end
      end
      RUN: begin
        if (!Halt) begin
          pc_d = pc_next;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        pc_d  = '0;
        cnt_d = '0;
      end
    endcase
  end

  assign ProgCtr   = pc_q;
  assign Running   = running_q;
  assign Done      = done_q;
  assign InstCount = cnt_q;

endmodule
